// File: rtl/msg_block_buf_if.sv
// Bundle of the byte-stream side (from the I/O interface) and the block side
// (to the BLAKE2s core) of the message block buffer.
interface msg_block_buf_if;
  logic [5:0]   kk_i;
  logic [63:0]  ll_i;
  logic         data_v_i;
  logic [7:0]   data_i;
  logic [5:0]   data_idx_i;
  logic         block_first_i;
  logic         block_last_i;
  logic         ready_o;
  logic         block_v_o;
  logic         block_ready_i;
  logic [511:0] m_o;
  logic [63:0]  t_o;
  logic         f_o;
  logic         first_o;
  logic         err_o;
  logic         state_dbg_o;

  // Handshakes: a byte transfers on any edge where data_v_i is high while
  // ready_o is high; a block transfers on an edge with block_v_o & block_ready_i.
  modport slave (
    input  kk_i, ll_i, data_v_i, data_i, data_idx_i, block_first_i,
           block_last_i, block_ready_i,
    output ready_o, block_v_o, m_o, t_o, f_o, first_o, err_o, state_dbg_o
  );

  modport master (
    output kk_i, ll_i, data_v_i, data_i, data_idx_i, block_first_i,
           block_last_i, block_ready_i,
    input  ready_o, block_v_o, m_o, t_o, f_o, first_o, err_o, state_dbg_o
  );
endinterface

// File: rtl/msg_block_buf.sv
// Collects a byte stream into a 64-byte BLAKE2s message block, computes the
// byte offset t and final flag, and presents the block to the compression core.
module msg_block_buf (
  input  logic          clk,
  input  logic          nreset,
  msg_block_buf_if.slave bus
);
  localparam int BLOCK_BYTES     = 64;
  localparam int KEY_BLOCK_BYTES = 64;
  localparam logic [5:0]  LAST_IDX  = 6'(BLOCK_BYTES - 1);
  localparam logic [63:0] BLK_INC   = 64'(BLOCK_BYTES);
  localparam logic [63:0] KEY_INC   = 64'(KEY_BLOCK_BYTES);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [511:0] m_q, m_d;
  logic [63:0]  t_q, t_d;
  logic         f_q, f_d;
  logic         first_q, first_d;
  logic         err_q, err_d;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    t_d     = t_q;
    f_d     = f_q;
    first_d = first_q;
    err_d   = err_q;
    case (state_q)
      FILL: begin
        if (bus.data_v_i) begin
          m_d[{bus.data_idx_i, 3'b000} +: 8] = bus.data_i;
          if (bus.data_idx_i == LAST_IDX) begin
            state_d = FULL;
            first_d = bus.block_first_i;
            f_d     = bus.block_last_i;
            // The last block carries the true total; earlier blocks count up.
            if (bus.block_last_i)
              t_d = bus.ll_i + ((bus.kk_i != 6'd0) ? KEY_INC : 64'd0);
            else if (bus.block_first_i)
              t_d = BLK_INC;
            else
              t_d = t_q + BLK_INC;
          end
        end
      end
      FULL: begin
        if (bus.data_v_i)
          err_d = 1'b1;
        if (bus.block_ready_i) begin
          state_d = FILL;
          if (f_q)
            t_d = 64'd0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= FILL;
      t_q     <= 64'd0;
      f_q     <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      f_q     <= f_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Block contents need no reset; the host always rewrites a full block.
  always_ff @(posedge clk) begin
    m_q <= m_d;
  end

  assign bus.ready_o     = (state_q == FILL);
  assign bus.block_v_o   = (state_q == FULL);
  assign bus.m_o         = m_q;
  assign bus.t_o         = t_q;
  assign bus.f_o         = f_q;
  assign bus.first_o     = first_q;
  assign bus.err_o       = err_q;
  assign bus.state_dbg_o = state_q;
endmodule
